shape_span_renderer: RTL and testbench
======================================

SHAPE_SPAN_RENDERER -- requirements
Module: shape_span_renderer

Interface
REQ-001 Parameter SPAN0, default 44: half-width in pixels on the first shape row.
REQ-002 Parameter INC0, default 33: signed span increment applied entering the second row.
REQ-003 Parameter DEC0, default 1: signed amount subtracted from the increment each row.
REQ-004 Parameter DDEC, default 0: signed amount added to the decrement each row; 0 gives the parabolic planet, nonzero gives the irregular third-order outline.
REQ-005 Parameter HEIGHT, default 60: number of shape rows.
REQ-006 Parameter COLOUR, default 3'b011: {R,G,B} driven inside the shape.
REQ-007 Parameters H_VISIBLE, default 640, and V_VISIBLE, default 480: visible raster limits.
REQ-008 clk  input  1  pixel clock; the only clock.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 HCounter  input  10  current pixel column.
REQ-011 VCounter  input  10  current raster line.
REQ-012 enable  input  1  shape visible when high; sampled at frame start.
REQ-013 pos_x  input  10  shape centre column; sampled at frame start.
REQ-014 pos_y  input  10  first shape row; sampled at frame start.
REQ-015 dR, dG, dB  output  1 each  registered pixel colour.
REQ-016 in_shape  output  1  registered; high when the current pixel is inside the shape.
REQ-017 frame_done  output  1  one-cycle pulse after the last shape row completes.

Function
REQ-018 Frame start is the cycle with HCounter==0 and VCounter==0; enable, pos_x and pos_y are latched only then, so a position change never tears a frame.
REQ-019 A new line is detected when VCounter differs from its value registered on the previous cycle; no logic is clocked by VCounter.
REQ-020 The FSM has states IDLE, WAIT_TOP, DRAW and DONE.
REQ-021 IDLE -> WAIT_TOP at frame start if the latched enable is 1; otherwise it stays in IDLE.
REQ-022 WAIT_TOP -> DRAW on the new line whose VCounter equals the latched pos_y, loading span=SPAN0, inc=INC0, dec=DEC0 and row=0.
REQ-023 In DRAW, each new line updates span+=inc, inc-=dec, dec+=DDEC and row+=1, all in the same cycle.
REQ-024 DRAW -> DONE on the new line where row reaches HEIGHT-1 +1; frame_done pulses for exactly that cycle.
REQ-025 DONE -> IDLE at the next frame start, where the enable/position latch and the IDLE rule apply in the same cycle.
REQ-026 span, inc and dec are 12-bit signed; span saturates at 0 (never negative) and at 1023.
REQ-027 Edges are computed in 12-bit signed: left=pos_x-span clipped to 0, and right=pos_x+span clipped to H_VISIBLE-1.
REQ-028 in_shape is asserted the cycle after HCounter satisfies left<=HCounter<=right while in DRAW and VCounter<V_VISIBLE (latency 1).
REQ-029 The pixel colour is COLOUR when in_shape is high, else 3'b000.
REQ-030 If pos_y+HEIGHT exceeds V_VISIBLE, rows beyond the visible area are not drawn, and DONE is still reached when the line count runs out or at the next frame start.
REQ-031 A frame start seen while in WAIT_TOP or DRAW aborts to IDLE processing, with no frame_done.

Reset
REQ-032 While rst is high: state=IDLE, span/inc/dec/row=0, latched enable=0, pos latches=0, and dR=dG=dB=in_shape=frame_done=0.
REQ-033 Deassertion mid-frame produces no drawing until the next frame start.

Structure
REQ-034 The FSM state encoding and the 12-bit span type belong in the shared package vga_pkg, together with H_VISIBLE and V_VISIBLE.
REQ-035 The span recurrence (span/inc/dec update with saturation) is one sub-module, span_stepper; edge compare and output registers stay in the top level.

Verification
REQ-036 Defaults, pos_x=464, pos_y=456, enable=1: line 456 draws columns 420..508; line 457 draws 387..541; line 458 draws 355..573.
REQ-037 Same setup: frame_done pulses once after line 515, and no pixels are drawn on line 516 or later.
REQ-038 SPAN0=10, INC0=-4, DEC0=0: span follows 10, 6, 2, 0, 0; rows 3 onward draw only column pos_x.
REQ-039 pos_x=5, SPAN0=44: line pos_y draws columns 0..49 (left clip); pos_x=630 draws 586..639 (right clip).
REQ-040 pos_x is changed mid-frame: the current frame is unchanged and the new position appears from the next frame.
REQ-041 rst is pulsed during line 470: outputs go to 0 immediately, and drawing resumes at line 456 of the following frame.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster limits, shape FSM encoding and 12-bit signed span type.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none; the raster is free-running.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;

   typedef logic signed [11:0] span_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TOP,
      DRAW,
      DONE
   } state_t;

   localparam span_t SPAN_MAX = 12'sd1023;

   // Clamp a widened span sum back into 0..1023 so the outline never inverts
   function automatic span_t sat_span(input logic signed [12:0] v);
      if (v < 13'sd0) begin
         return '0;
      end else if (v > 13'sd1023) begin
         return SPAN_MAX;
      end else begin
         return v[11:0];
      end
   endfunction

endpackage

// File: rtl/span_stepper.sv
// span_stepper: per-row half-width recurrence (span += inc, inc -= dec, dec += DDEC).
// Latency: span_d is the combinational next value; state registers update on the clock.
// Backpressure: none; load restarts at the first row, step advances one row.
module span_stepper
   import vga_pkg::*;
#(
   parameter int SPAN0 = 44,
   parameter int INC0  = 33,
   parameter int DEC0  = 1,
   parameter int DDEC  = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  step,
   output span_t span_d
);

   span_t span_q;
   span_t inc_q;
   span_t inc_d;
   span_t dec_q;
   span_t dec_d;

   // Next-row values; span_d is exported so the top can draw with the value taking effect this line
   always_comb begin
      span_d = span_q;
      inc_d  = inc_q;
      dec_d  = dec_q;
      if (load) begin
         span_d = span_t'(SPAN0);
         inc_d  = span_t'(INC0);
         dec_d  = span_t'(DEC0);
      end else if (step) begin
         // Widen before adding so 1023 + large inc saturates instead of wrapping negative
         span_d = sat_span(13'(span_q) + 13'(inc_q));
         inc_d  = inc_q - dec_q;
         dec_d  = dec_q + span_t'(DDEC);
      end
   end

   // Recurrence state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         span_q <= '0;
         inc_q  <= '0;
         dec_q  <= '0;
      end else begin
         span_q <= span_d;
         inc_q  <= inc_d;
         dec_q  <= dec_d;
      end
   end

endmodule

// File: rtl/shape_span_renderer.sv
// shape_span_renderer: draws a row-by-row span-stepped shape into a VGA raster.
// Latency: 1 cycle from HCounter/VCounter to in_shape and colour outputs.
// Backpressure: none; follows the free-running raster counters.
module shape_span_renderer #(
   parameter int         SPAN0     = 44,
   parameter int         INC0      = 33,
   parameter int         DEC0      = 1,
   parameter int         DDEC      = 0,
   parameter int         HEIGHT    = 60,
   parameter logic [2:0] COLOUR    = 3'b011,
   parameter int         H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int         V_VISIBLE = vga_pkg::V_VISIBLE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] HCounter,
   input  logic [9:0] VCounter,
   input  logic       enable,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   output logic       dR,
   output logic       dG,
   output logic       dB,
   output logic       in_shape,
   output logic       frame_done
);

   import vga_pkg::span_t, vga_pkg::state_t, vga_pkg::IDLE, vga_pkg::WAIT_TOP,
          vga_pkg::DRAW, vga_pkg::DONE;

   state_t      state_q, state_d;
   logic [10:0] row_q, row_d;
   logic        en_q, en_d;
   logic [9:0]  posx_q, posx_d;
   logic [9:0]  posy_q, posy_d;
   logic [9:0]  vcnt_q;
   logic        in_shape_q, in_shape_d;
   logic [2:0]  rgb_q, rgb_d;
   logic        frame_done_q, frame_done_d;
   logic        frame_start, new_line, load, step;
   span_t       span_d;
   span_t       px, hc, left_raw, right_raw, left_e, right_e;

   span_stepper #(
      .SPAN0 (SPAN0),
      .INC0  (INC0),
      .DEC0  (DEC0),
      .DDEC  (DDEC)
   ) u_stepper (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .span_d (span_d)
   );

   // Frame/line detection, position latching and shape FSM next state
   always_comb begin
      frame_start  = (HCounter == 10'd0) && (VCounter == 10'd0);
      new_line     = (VCounter != vcnt_q);
      state_d      = state_q;
      row_d        = row_q;
      en_d         = en_q;
      posx_d       = posx_q;
      posy_d       = posy_q;
      load         = 1'b0;
      step         = 1'b0;
      frame_done_d = 1'b0;
      if (frame_start) begin
         // Any state restarts here, so a late or aborted frame never signals done
         en_d   = enable;
         posx_d = pos_x;
         posy_d = pos_y;
         if (!en_d) begin
            state_d = IDLE;
         end else if (new_line && (posy_d == VCounter)) begin
            state_d = DRAW;
            load    = 1'b1;
            row_d   = '0;
         end else begin
            state_d = WAIT_TOP;
         end
      end else begin
         case (state_q)
            WAIT_TOP: begin
               if (new_line && (VCounter == posy_q)) begin
                  state_d = DRAW;
                  load    = 1'b1;
                  row_d   = '0;
               end
            end
            DRAW: begin
               if (new_line) begin
                  if (row_q == 11'(HEIGHT - 1)) begin
                     state_d      = DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     step  = 1'b1;
                     row_d = row_q + 11'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Edge compare uses next-state values so the first pixel of each line is already correct
   always_comb begin
      px         = span_t'({2'b00, posx_d});
      hc         = span_t'({2'b00, HCounter});
      left_raw   = px - span_d;
      right_raw  = px + span_d;
      left_e     = (left_raw < 12'sd0) ? 12'sd0 : left_raw;
      right_e    = (right_raw > span_t'(H_VISIBLE - 1)) ? span_t'(H_VISIBLE - 1) : right_raw;
      in_shape_d = (state_d == DRAW) && (32'(VCounter) < V_VISIBLE) &&
                   (hc >= left_e) && (hc <= right_e);
      rgb_d      = in_shape_d ? COLOUR : 3'b000;
   end

   // FSM state, frame latches, line tracker and registered pixel outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         en_q         <= 1'b0;
         posx_q       <= '0;
         posy_q       <= '0;
         vcnt_q       <= '0;
         in_shape_q   <= 1'b0;
         rgb_q        <= 3'b000;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         en_q         <= en_d;
         posx_q       <= posx_d;
         posy_q       <= posy_d;
         vcnt_q       <= VCounter;
         in_shape_q   <= in_shape_d;
         rgb_q        <= rgb_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign in_shape       = in_shape_q;
   assign {dR, dG, dB}   = rgb_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_shape_span_renderer.sv
// tb_shape_span_renderer: raster-driven scoreboard bench for two renderer configurations.
// Latency: expected pixel pushed at drive, popped one clock later.
// Backpressure: none; the bench owns the raster counters.
module tb_shape_span_renderer;

   localparam int         HEIGHT  = 60;
   localparam logic [2:0] COL     = 3'b011;
   localparam int         V_TOTAL = 525;
   localparam int         H_FULL  = 660;
   localparam int         H_SHORT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] HCounter, VCounter, pos_x, pos_y;
   logic       enable;
   logic       dR, dG, dB, in_shape, frame_done;
   logic       r2, g2, b2, in_shape2, frame_done2;

   typedef struct {
      int         h;
      int         v;
      logic [4:0] e1;
      logic [4:0] e2;
   } sb_t;

   sb_t sbq[$];

   int n_cmp = 0;
   int n_bad = 0;
   int m_act, m_px, m_py;
   int first1[0:V_TOTAL-1];
   int last1[0:V_TOTAL-1];
   int first2[0:V_TOTAL-1];
   int last2[0:V_TOTAL-1];
   int done1_cnt, done1_line, done2_cnt;

   always #5 clk = ~clk;

   shape_span_renderer dut (
      .clk(clk), .rst(rst), .HCounter(HCounter), .VCounter(VCounter),
      .enable(enable), .pos_x(pos_x), .pos_y(pos_y),
      .dR(dR), .dG(dG), .dB(dB), .in_shape(in_shape), .frame_done(frame_done)
   );

   shape_span_renderer #(.SPAN0(10), .INC0(-4), .DEC0(0)) dut2 (
      .clk(clk), .rst(rst), .HCounter(HCounter), .VCounter(VCounter),
      .enable(enable), .pos_x(pos_x), .pos_y(pos_y),
      .dR(r2), .dG(g2), .dB(b2), .in_shape(in_shape2), .frame_done(frame_done2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // Closed-form span per row, clamped; pixel inside when |h - pos_x| <= span on a visible pixel
   function automatic logic [4:0] model_px(input int h, input int v, input int s0,
                                           input int i0, input int d0);
      int   row, sp;
      logic ins;
      row = v - m_py;
      ins = 1'b0;
      if (m_act != 0 && row >= 0 && row < HEIGHT && v < 480 && h < 640) begin
         sp = s0 + i0 * row - (d0 * row * (row - 1)) / 2;
         if (sp < 0) sp = 0;
         if (sp > 1023) sp = 1023;
         ins = (h >= m_px - sp) && (h <= m_px + sp);
      end
      return {(m_act != 0 && row == HEIGHT && h == 0), ins, (ins ? COL : 3'b000)};
   endfunction

   function automatic bit is_full(input int v);
      return (v >= 456 && v <= 460) || v == 470 || v == 479 || v == 480 || v == 515 || v == 516;
   endfunction

   task automatic cycle(input int h, input int v);
      sb_t        e, n;
      logic [4:0] g1, g2v;
      @(negedge clk);
      if (sbq.size() > 0) begin
         e   = sbq.pop_front();
         g1  = {frame_done, in_shape, dR, dG, dB};
         g2v = {frame_done2, in_shape2, r2, g2, b2};
         chk($sformatf("pix1 v%0d h%0d", e.v, e.h), 32'(g1), 32'(e.e1));
         chk($sformatf("pix2 v%0d h%0d", e.v, e.h), 32'(g2v), 32'(e.e2));
         if (g1[3] === 1'b1) begin
            if (first1[e.v] < 0) first1[e.v] = e.h;
            last1[e.v] = e.h;
         end
         if (g2v[3] === 1'b1) begin
            if (first2[e.v] < 0) first2[e.v] = e.h;
            last2[e.v] = e.h;
         end
         if (g1[4] === 1'b1) begin
            done1_cnt++;
            done1_line = e.v;
         end
         if (g2v[4] === 1'b1) done2_cnt++;
      end
      HCounter = 10'(h);
      VCounter = 10'(v);
      if (h == 0 && v == 0) begin
         m_act = int'(enable);
         m_px  = int'(pos_x);
         m_py  = int'(pos_y);
      end
      n.h  = h;
      n.v  = v;
      n.e1 = model_px(h, v, 44, 33, 1);
      n.e2 = model_px(h, v, 10, -4, 0);
      sbq.push_back(n);
   endtask

   task automatic run_frame(input int rst_line, input int chg_line, input int chg_x);
      int len;
      for (int i = 0; i < V_TOTAL; i++) begin
         first1[i] = -1; last1[i] = -1; first2[i] = -1; last2[i] = -1;
      end
      done1_cnt = 0; done1_line = -1; done2_cnt = 0;
      for (int v = 0; v < V_TOTAL; v++) begin
         len = is_full(v) ? H_FULL : H_SHORT;
         for (int h = 0; h < len; h++) begin
            if (v == chg_line && h == 0) pos_x = 10'(chg_x);
            cycle(h, v);
            if (v == rst_line && h == 100) begin
               #2 rst = 1'b1;
               #1 chk("rst_async", 32'({frame_done, in_shape, dR, dG, dB}), 0);
               sbq.delete();
               m_act = 0;
            end
            if (v == rst_line && h == 104) begin
               #1 rst = 1'b0;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; HCounter = '0; VCounter = '0;
      enable = 1'b1; pos_x = 10'd464; pos_y = 10'd456;
      m_act = 0; m_px = 0; m_py = 0;
      repeat (3) @(negedge clk);
      chk("reset_out1", 32'({frame_done, in_shape, dR, dG, dB}), 0);
      chk("reset_out2", 32'({frame_done2, in_shape2, r2, g2, b2}), 0);
      rst = 1'b0;

      // Baseline parabola plus the decreasing-span configuration
      run_frame(-1, -1, 0);
      chk("f0 l456 left", first1[456], 420);
      chk("f0 l456 right", last1[456], 508);
      chk("f0 l457 left", first1[457], 387);
      chk("f0 l457 right", last1[457], 541);
      chk("f0 l458 left", first1[458], 355);
      chk("f0 l458 right", last1[458], 573);
      chk("f0 l516 blank", first1[516], -1);
      chk("f0 done count", done1_cnt, 1);
      chk("f0 done line", done1_line, 516);
      chk("f0 d2 l456 left", first2[456], 454);
      chk("f0 d2 l457 right", last2[457], 470);
      chk("f0 d2 l458 left", first2[458], 462);
      chk("f0 d2 l459 left", first2[459], 464);
      chk("f0 d2 l460 right", last2[460], 464);
      chk("f0 d2 done count", done2_cnt, 1);

      // Left clip, with a mid-frame position change that must not take effect yet
      pos_x = 10'd5;
      run_frame(-1, 457, 630);
      chk("f1 l456 left", first1[456], 0);
      chk("f1 l456 right", last1[456], 49);
      chk("f1 l458 right", last1[458], 114);

      // Right clip: the new position from the previous frame now applies
      run_frame(-1, -1, 0);
      chk("f2 l456 left", first1[456], 586);
      chk("f2 l456 right", last1[456], 639);

      // Reset pulse during line 470 kills the rest of the frame
      pos_x = 10'd464;
      run_frame(470, -1, 0);
      chk("f3 l479 blank", first1[479], -1);
      chk("f3 done count", done1_cnt, 0);

      // Drawing resumes on the following frame
      run_frame(-1, -1, 0);
      chk("f4 l456 left", first1[456], 420);
      chk("f4 l456 right", last1[456], 508);
      chk("f4 done count", done1_cnt, 1);

      // Disabled frame draws nothing
      enable = 1'b0;
      run_frame(-1, -1, 0);
      chk("f5 l456 blank", first1[456], -1);
      chk("f5 done count", done1_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
